// File: rtl/keccak_slice_pkg.sv
// Shared types for the slice-serial permutation datapath.
package keccak_slice_pkg;

  localparam int N      = 25;
  localparam int SLICES = 64;
  localparam int CW     = 7;

  typedef logic [N-1:0] slice_t;

  typedef struct packed {
    slice_t     s;
    logic [5:0] z;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE,
    ONE,
    TWO
  } skid_state_e;

  function automatic int idx(input int x, input int y);
    return 5 * y + x;
  endfunction

endpackage

// File: rtl/chi_row.sv
// Chi on one 5-bit row: b[x] = a[x] ^ (~a[x+1] & a[x+2]).
module chi_row (
  input  logic [4:0] a,
  output logic [4:0] b
);

  always_comb begin
    b = '0;
    for (int x = 0; x < 5; x++) begin
      b[x] = a[x] ^ (~a[(x + 1) % 5] & a[(x + 2) % 5]);
    end
  end

endmodule

// File: rtl/chi_stage.sv
// Streaming chi stage with two-entry skid buffer.
// Optional iota XOR on lane (0,0) when CHI_IOTA_EN is defined.
module chi_stage
  import keccak_slice_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_slice,
  input  logic [63:0]  rc,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_slice,
  output logic [5:0]   out_idx,
  output logic         frame_done
);

  skid_state_e state_q, state_d;
  entry_t      head_q, head_d;
  entry_t      tail_q, tail_d;
  logic [5:0]  in_z_q, in_z_d;
  logic        in_ready_q;
  logic        out_valid_q;
  slice_t      chi_s;
  slice_t      new_s;
  logic        in_hs;
  logic        out_hs;

  for (genvar y = 0; y < 5; y++) begin : g_row
    chi_row u_row (
      .a (in_slice[idx(0, y) +: 5]),
      .b (chi_s[idx(0, y) +: 5])
    );
  end

`ifdef CHI_IOTA_EN
  assign new_s = chi_s ^ {{(N-1){1'b0}}, rc[in_z_q]};
`else
  logic unused_rc;
  assign unused_rc = ^rc;
  assign new_s     = chi_s;
`endif

  assign in_hs  = in_valid & in_ready_q;
  assign out_hs = out_valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    in_z_d  = in_z_q;
    if (in_hs) begin
      in_z_d = (in_z_q == 6'd0) ? 6'd63 : in_z_q - 6'd1;
    end
    unique case (state_q)
      IDLE: begin
        if (in_hs) begin
          state_d = ONE;
          head_d  = '{s: new_s, z: in_z_q};
        end
      end
      ONE: begin
        unique case (1'b1)
          (in_hs & ~out_hs): begin
            state_d = TWO;
            tail_d  = '{s: new_s, z: in_z_q};
          end
          (out_hs & ~in_hs): begin
            state_d = IDLE;
          end
          (in_hs & out_hs): begin
            head_d = '{s: new_s, z: in_z_q};
          end
          default: ;
        endcase
      end
      TWO: begin
        if (out_hs) begin
          state_d = ONE;
          head_d  = tail_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      head_q      <= '0;
      tail_q      <= '0;
      in_z_q      <= 6'd63;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      in_z_q      <= in_z_d;
      in_ready_q  <= (state_d != TWO);
      out_valid_q <= (state_d != IDLE);
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_slice  = head_q.s;
  assign out_idx    = head_q.z;
  assign frame_done = out_hs & (head_q.z == 6'd0);

endmodule

// File: tb/tb_chi_stage.sv
// Randomized self-checking bench for chi_stage.
// Reference: a FIFO of expected (slice, z) entries computed from the chi rule.
module tb_chi_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [24:0] in_slice;
  logic [63:0] rc;
  logic        out_valid;
  logic        out_ready;
  logic [24:0] out_slice;
  logic [5:0]  out_idx;
  logic        frame_done;

  chi_stage dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_slice   (in_slice),
    .rc         (rc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_slice  (out_slice),
    .out_idx    (out_idx),
    .frame_done (frame_done)
  );

  typedef struct {
    logic [24:0] s;
    logic [5:0]  z;
  } exp_t;

  exp_t q[$];
  int   mz;
  int   errors;
  int   checks;
  int   acc_cnt;
  int   fd_cnt;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [24:0] chi_m(input logic [24:0] a, input logic r);
    logic [24:0] o;
    o = '0;
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++)
        o[5*y+x] = a[5*y+x] ^ (~a[5*y+(x+1)%5] & a[5*y+(x+2)%5]);
`ifdef CHI_IOTA_EN
    o[0] = o[0] ^ r;
`else
    if (r) o = o;
`endif
    return o;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic compare();
    bit hs_in, hs_out;
    if (!rst) return;
    chk("out_valid", out_valid, q.size() > 0);
    chk("in_ready", in_ready, q.size() < 2);
    hs_out = (q.size() > 0) && out_ready;
    hs_in  = in_valid && (q.size() < 2);
    if (q.size() > 0) begin
      chk("out_slice", out_slice, q[0].s);
      chk("out_idx", out_idx, q[0].z);
      chk("frame_done", frame_done, hs_out && (q[0].z == 6'd0));
    end else begin
      chk("frame_done_idle", frame_done, 0);
    end
    if (frame_done) fd_cnt++;
    if (hs_in) acc_cnt++;
    if (hs_out) void'(q.pop_front());
    if (hs_in) begin
      q.push_back('{s: chi_m(in_slice, rc[mz]), z: 6'(mz)});
      mz = (mz == 0) ? 63 : mz - 1;
    end
  endtask

  task automatic tick(input logic v, input logic [24:0] s, input logic r);
    in_valid  = v;
    in_slice  = s;
    out_ready = r;
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_slice", out_slice, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_frame_done", frame_done, 0);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    acc_cnt   = 0;
    fd_cnt    = 0;
    mz        = 63;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_slice  = '0;
    out_ready = 1'b0;
    rc        = 64'h8000000000000000;
    #12;
    check_reset_outputs();
    release_reset();

    tick(1'b1, 25'h0000000, 1'b1);
`ifdef CHI_IOTA_EN
    chk("lit_zero_iota", out_slice, 25'h0000001);
`else
    chk("lit_zero", out_slice, 25'h0000000);
`endif
    chk("lit_idx63", out_idx, 63);
    chk("lit_valid1", out_valid, 1);
    tick(1'b1, 25'h0000001, 1'b1);
    chk("lit_one", out_slice, 25'h0000009);
    chk("lit_idx62", out_idx, 62);
    tick(1'b1, 25'h1FFFFFF, 1'b1);
    chk("lit_ones", out_slice, 25'h1FFFFFF);
    for (int i = 0; i < 61; i++) tick(1'b1, 25'($urandom), 1'b1);
    for (int i = 0; i < 3; i++) tick(1'b0, '0, 1'b1);
    chk("lit_frame_done_once", fd_cnt, 1);

    fd_cnt = 0;
    for (int i = 0; i < 64; i++) tick(1'b1, 25'($urandom), 1'b1);
    for (int i = 0; i < 3; i++) tick(1'b0, '0, 1'b1);
    chk("lit_frame2_done", fd_cnt, 1);

    acc_cnt = 0;
    for (int i = 0; i < 5; i++) tick(1'b1, 25'($urandom), 1'b0);
    chk("lit_bp_accepts", acc_cnt, 2);
    chk("lit_bp_in_ready", in_ready, 0);
    for (int i = 0; i < 6; i++) tick(1'b0, '0, 1'b1);
    chk("lit_bp_drained", out_valid, 0);

    for (int i = 0; i < 400; i++) begin
      if (mz == 63) rc = {$urandom, $urandom};
      tick(1'($urandom_range(0, 3) != 0), 25'($urandom),
           1'($urandom_range(0, 2) != 0));
    end
    for (int i = 0; i < 4; i++) tick(1'b0, '0, 1'b1);

    while (mz != 63) tick(1'b1, 25'($urandom), 1'b1);
    for (int i = 0; i < 20; i++) tick(1'b1, 25'($urandom), 1'b1);
    rst = 1'b0;
    #1;
    check_reset_outputs();
    q.delete();
    mz = 63;
    release_reset();
    tick(1'b1, 25'($urandom), 1'b1);
    chk("lit_post_rst_idx", out_idx, 63);
    chk("lit_post_rst_valid", out_valid, 1);

    for (int i = 0; i < 200; i++) begin
      if (mz == 63) rc = {$urandom, $urandom};
      tick(1'($urandom_range(0, 1)), 25'($urandom),
           1'($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 4; i++) tick(1'b0, '0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/chi_stage.md
# chi_stage

Streaming chi step of the slice-serial permutation datapath. Sits directly downstream of the permute (pi) stage and consumes its 25-bit slices one per handshake, z = 63 down to 0. Each slice gets the row-wise non-linear chi transform, optionally merged with the iota round-constant XOR, and is forwarded through a two-entry skid buffer. This sustains full throughput under backpressure.

## Interface
- N, 25, slice width (5x5 lanes, bit index i = 5*y + x)
- SLICES, 64, slices per frame
- CW, 7, slice counter width
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream slice valid
- in_ready  out  1  stage can accept a slice
- in_slice  in  N  slice from pi stage
- rc  in  64  round constant for current round, bit z applies to slice z; held stable for the whole frame
- out_valid  out  1  output slice valid
- out_ready  in  1  downstream accepts
- out_slice  out  N  chi (and optionally iota) result
- out_idx  out  6  z index of out_slice
- frame_done  out  1  one-cycle pulse when slice z=0 is accepted downstream

## Operation
- Chi per slice, for row y and column x (mod 5): out[x,y] = a[x,y] ^ (~a[x+1,y] & a[x+2,y]).
- Input counter in_z:
  - reset value 63; decrements on each input handshake (in_valid & in_ready).
  - After accepting z=0 it reloads 63. Wrap-around is not an error.
- The captured z travels with its slice as out_idx.
- FSM:
  - IDLE (buffer empty) -> ONE on input handshake.
  - ONE -> TWO on input without output handshake.
  - ONE -> IDLE on output without input handshake.
  - TWO -> ONE on output handshake.
  - Simultaneous input and output handshake in ONE stays in ONE.
- in_ready = (state != TWO). The input is never accepted when full.
- out_valid = (state != IDLE). The head entry is presented; the second entry shifts to head on output handshake.
- Chi is computed before the buffer, so buffered data is final. Holding out_ready low never changes out_slice or out_idx while out_valid is high.
- frame_done = output handshake & out_idx == 0.
- Reset (any time, including mid-frame) forces the following at once:
  - state IDLE, in_z 63.
  - out_valid 0, in_ready 0 while rst low, out_slice 0, out_idx 0, frame_done 0.
  - A partial frame is discarded. The next accepted slice is z=63.

## Timing
- Latency: slice accepted at edge k gives out_valid high after edge k (visible cycle k+1), with no bubble.
- Throughput: 1 slice/cycle while out_ready stays high. 64-slice frame completes in 65 cycles from the first accept.
- in_ready is a registered decode of state. There is no combinational path from out_ready to in_ready.
- frame_done is registered-aligned with the z=0 output handshake cycle.
- rc is sampled at input handshake for bit in_z.

## Configuration
- CHI_IOTA_EN defined:
  - Output bit 0 (lane x=0,y=0) of slice z is additionally XORed with rc[z] after chi.
  - The rc port is used.
- Not defined:
  - Pure chi; rc is ignored (port retained, unconnected internally).
  - Iota is performed elsewhere.

## Structure
- Shared package keccak_slice_pkg:
  - N, SLICES, CW constants.
  - Slice type (logic [N-1:0]).
  - Lane index function idx(x,y) = 5*y + x.
  - Skid FSM state enum {IDLE, ONE, TWO}.
- Sub-module chi_row: combinational 5-bit row transform, instantiated 5 times (one per y).
- Top holds the counter, FSM, two slice+index entry registers, and optional iota XOR.

## Test plan
- Single slice 25'h0000000 at z=63 -> out_slice 25'h0000000, out_idx 63, one cycle later.
- Slice 25'h0000001 -> out_slice 25'h0000009. Slice 25'h1FFFFFF -> 25'h1FFFFFF.
- Full 64-slice frame, out_ready constant 1 -> out_idx 63..0 on consecutive cycles, frame_done exactly once, with idx 0; second frame restarts at 63.
- out_ready low 5 cycles while in_valid high -> exactly 2 slices accepted, in_ready low; on release all slices emerge in order, none lost or duplicated.
- CHI_IOTA_EN, rc = 64'h8000000000000000, zero slice at z=63 -> 25'h0000001. Without macro -> 25'h0000000.
- rst asserted after 20 slices -> out_valid 0, out_slice 0 immediately (asynchronous). After release the first accepted slice is reported as out_idx 63.
